// File: rtl/spi_dac_multi_out_pkg.sv
// Shared definitions for the LTC2624-class multi-channel DAC driver:
// command and address codes, sequencer states and the word builder.
package spi_dac_multi_out_pkg;

  localparam int WORD_W = 24;

  // LTC2624 command nibbles
  localparam logic [3:0] CMD_WRITE         = 4'b0000;  // write input register n
  localparam logic [3:0] CMD_UPDATE        = 4'b0001;  // update DAC register n
  localparam logic [3:0] CMD_WRITE_UPD_ALL = 4'b0010;  // write n, update all
  localparam logic [3:0] CMD_WRITE_UPD     = 4'b0011;  // write and update n

  // LTC2624 address nibbles
  localparam logic [3:0] DAC_A   = 4'h0;
  localparam logic [3:0] DAC_B   = 4'h1;
  localparam logic [3:0] DAC_C   = 4'h2;
  localparam logic [3:0] DAC_D   = 4'h3;
  localparam logic [3:0] DAC_ALL = 4'hF;

  // Channel sequencer states
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_SHIFT = 2'd2,
    ST_GAP   = 2'd3
  } state_e;

  // Assemble the 24-bit frame {cmd, addr, 16-bit data field}
  function automatic logic [WORD_W-1:0] build_word(input logic [3:0]  cmd,
                                                   input logic [3:0]  addr,
                                                   input logic [15:0] data);
    return {cmd, addr, data};
  endfunction

endpackage

// File: rtl/spi_dac_multi_out_word_tx.sv
// Serialises one 24-bit word MSB first. Each bit period is CLK_DIV clks:
// SCK low for the first half (SDO settles), high for the second half.
// SDO advances on the falling edge that ends each bit; done_o is high on
// the last clk of the 24th bit.
module spi_dac_multi_out_word_tx
  import spi_dac_multi_out_pkg::*;
#(
  parameter int CLK_DIV = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start_i,
  input  logic [WORD_W-1:0] word_i,
  output logic              sck_o,
  output logic              sdo_o,
  output logic              done_o
);

  localparam int                DIV_W    = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
  localparam logic [DIV_W-1:0]  DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [DIV_W-1:0]  DIV_HALF = DIV_W'(CLK_DIV / 2);
  localparam logic [DIV_W-1:0]  DIV_ONE  = DIV_W'(1);
  localparam logic [4:0]        BIT_LAST = 5'(WORD_W - 1);

  logic              active_q;
  logic [DIV_W-1:0]  div_q;
  logic [4:0]        bit_q;
  logic [WORD_W-1:0] shreg_q;
  logic              sck_q;
  logic              period_end;

  assign period_end = active_q && (div_q == DIV_LAST);
  assign done_o     = period_end && (bit_q == BIT_LAST);
  assign sck_o      = sck_q;
  assign sdo_o      = shreg_q[WORD_W-1];

  // Divider, bit counter and shift register; shifting in zeros leaves SDO low after the word
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      active_q <= 1'b0;
      div_q    <= '0;
      bit_q    <= '0;
      shreg_q  <= '0;
      sck_q    <= 1'b0;
    end else if (start_i) begin
      active_q <= 1'b1;
      div_q    <= '0;
      bit_q    <= '0;
      shreg_q  <= word_i;
      sck_q    <= 1'b0;
    end else if (active_q) begin
      if (period_end) begin
        div_q   <= '0;
        sck_q   <= 1'b0;
        shreg_q <= {shreg_q[WORD_W-2:0], 1'b0};
        if (done_o) active_q <= 1'b0;
        else        bit_q    <= bit_q + 5'd1;
      end else begin
        div_q <= div_q + DIV_ONE;
        sck_q <= ((div_q + DIV_ONE) >= DIV_HALF);
      end
    end
  end

endmodule

// File: rtl/spi_dac_multi_out.sv
// Multi-channel LTC2624 driver: frame timer, per-frame snapshot of samples
// and channel mask, lowest-first channel sequencer and command selection.
// One 24-bit word is sent per enabled channel each frame.
module spi_dac_multi_out
  import spi_dac_multi_out_pkg::*;
#(
  parameter int CHANNELS  = 4,
  parameter int DATA_W    = 12,
  parameter int CLK_DIV   = 2,
  parameter int CS_GAP    = 2,
  parameter int CYC_W     = 16,
  parameter int SIMUL_UPD = 0
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic [CYC_W-1:0]           cycles,
  input  logic [CHANNELS*DATA_W-1:0] data_in,
  input  logic [CHANNELS-1:0]        ch_mask,
  output logic                       spi_sck,
  output logic                       spi_sdo,
  output logic                       spi_dac_cs,
  output logic                       ena_out,
  output logic                       busy,
  output logic                       overrun,
  output state_e                     dbg_state
);

  localparam int               GAP_W    = $clog2(CS_GAP + 1);
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(CS_GAP - 1);
  localparam logic [CYC_W-1:0] CYC_MIN  = CYC_W'(2);
  localparam logic [CYC_W-1:0] CYC_ONE  = CYC_W'(1);

  state_e                     state_q, state_d;
  logic [CYC_W-1:0]           timer_q, timer_d;
  logic [CYC_W-1:0]           cyc_q;
  logic [CHANNELS-1:0]        pend_q, pend_d;
  logic [CHANNELS*DATA_W-1:0] data_q;
  logic [GAP_W-1:0]           gap_q, gap_d;
  logic                       cs_q, ena_q, ovr_q, ovr_seen_q;

  logic [CYC_W-1:0]    cyc_eff;
  logic [CHANNELS-1:0] pend_rest;
  logic                terminal, last_word, gap_last, fsm_free, frame_start, ovr_d;
  logic [3:0]          sel_addr, cmd;
  logic [DATA_W-1:0]   sel_sample;
  logic [15:0]         data16;
  logic [WORD_W-1:0]   word;
  logic                tx_done;

  assign cyc_eff   = (cyc_q < CYC_MIN) ? CYC_MIN : cyc_q;
  assign terminal  = (timer_q >= (cyc_eff - CYC_ONE));
  assign pend_rest = pend_q & (pend_q - CHANNELS'(1));  // pending with lowest bit cleared
  assign last_word = (pend_rest == '0);
  assign gap_last  = (state_q == ST_GAP) && (gap_q == GAP_LAST);
  // The sequencer is free on its final GAP cycle, so a stretched frame restarts
  // with no extra idle clock and lasts exactly N word slots.
  assign fsm_free    = (state_q == ST_IDLE) || (gap_last && last_word);
  assign frame_start = terminal && fsm_free;
  assign ovr_d       = terminal && (state_q != ST_IDLE) && !fsm_free && !ovr_seen_q;

  // Pick the lowest pending channel and its snapshotted sample
  always_comb begin
    sel_addr   = '0;
    sel_sample = '0;
    for (int k = CHANNELS - 1; k >= 0; k--) begin
      if (pend_q[k]) begin
        sel_addr   = 4'(k);
        sel_sample = data_q[k*DATA_W +: DATA_W];
      end
    end
  end

  // Command choice: the final (highest) channel of a frame triggers the shared update
  always_comb begin
    cmd = CMD_WRITE_UPD;
    if (SIMUL_UPD != 0) cmd = last_word ? CMD_WRITE_UPD_ALL : CMD_WRITE;
  end

  assign data16 = 16'(sel_sample) << (16 - DATA_W);
  assign word   = build_word(cmd, sel_addr, data16);

  // Sequencer next state, pending mask and gap counter
  always_comb begin
    state_d = state_q;
    pend_d  = pend_q;
    gap_d   = '0;
    case (state_q)
      ST_IDLE:  if (frame_start && (ch_mask != '0)) state_d = ST_LOAD;
      ST_LOAD:  state_d = ST_SHIFT;
      ST_SHIFT: if (tx_done) state_d = ST_GAP;
      ST_GAP: begin
        if (!gap_last)                           gap_d   = gap_q + GAP_W'(1);
        else if (!last_word)                     state_d = ST_LOAD;
        else if (frame_start && (ch_mask != '0)) state_d = ST_LOAD;
        else                                     state_d = ST_IDLE;
      end
      default:  state_d = ST_IDLE;
    endcase
    if (frame_start)   pend_d = ch_mask;
    else if (gap_last) pend_d = pend_rest;
  end

  // Frame timer: clears at frame start, holds at terminal count while a frame overruns
  always_comb begin
    if (frame_start)   timer_d = '0;
    else if (terminal) timer_d = timer_q;
    else               timer_d = timer_q + CYC_ONE;
  end

  // Sequencer state register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= ST_IDLE;
    else          state_q <= state_d;
  end

  // Timer, frame snapshot, chip select and status pulses
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      timer_q    <= '0;
      cyc_q      <= '0;
      pend_q     <= '0;
      data_q     <= '0;
      gap_q      <= '0;
      cs_q       <= 1'b1;
      ena_q      <= 1'b0;
      ovr_q      <= 1'b0;
      ovr_seen_q <= 1'b0;
    end else begin
      timer_q <= timer_d;
      pend_q  <= pend_d;
      gap_q   <= gap_d;
      cs_q    <= !((state_d == ST_LOAD) || (state_d == ST_SHIFT));
      ena_q   <= frame_start;
      ovr_q   <= ovr_d;
      if (frame_start) begin
        cyc_q      <= cycles;
        data_q     <= data_in;
        ovr_seen_q <= 1'b0;
      end else if (ovr_d) begin
        ovr_seen_q <= 1'b1;
      end
    end
  end

  spi_dac_multi_out_word_tx #(.CLK_DIV(CLK_DIV)) u_tx (
    .clk     (clk),
    .rst_n   (reset_n),
    .start_i (state_q == ST_LOAD),
    .word_i  (word),
    .sck_o   (spi_sck),
    .sdo_o   (spi_sdo),
    .done_o  (tx_done)
  );

  assign spi_dac_cs = cs_q;
  assign ena_out    = ena_q;
  assign busy       = (state_q != ST_IDLE);
  assign overrun    = ovr_q;
  assign dbg_state  = state_q;

endmodule

// File: tb/tb_spi_dac_multi_out.sv
// Bench for spi_dac_multi_out. Two instances share all inputs: lane 0 uses
// per-word update (SIMUL_UPD=0), lane 1 uses simultaneous update (SIMUL_UPD=1).
// At each frame start the reference model turns the snapshotted inputs into
// the expected word list, frame period and overrun count; a monitor decodes
// the SPI bus and compares every completed word against the queue.
module tb_spi_dac_multi_out;
  import spi_dac_multi_out_pkg::*;

  localparam int CHANNELS  = 4;
  localparam int DATA_W    = 12;
  localparam int CLK_DIV   = 2;
  localparam int CS_GAP    = 2;
  localparam int CYC_W     = 16;
  localparam int WORD_CLKS = 1 + 24*CLK_DIV + CS_GAP;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  logic [CYC_W-1:0]           cycles;
  logic [CHANNELS*DATA_W-1:0] data_in;
  logic [CHANNELS-1:0]        ch_mask;

  logic   sck [2];
  logic   sdo [2];
  logic   cs  [2];
  logic   ena [2];
  logic   busy[2];
  logic   ovr [2];
  state_e dbg [2];

  int errors = 0;
  int checks = 0;
  int q_size[2];

  spi_dac_multi_out #(.CHANNELS(CHANNELS), .DATA_W(DATA_W), .CLK_DIV(CLK_DIV),
                      .CS_GAP(CS_GAP), .CYC_W(CYC_W), .SIMUL_UPD(0)) u_dut0 (
    .clk(clk), .reset_n(reset_n), .cycles(cycles), .data_in(data_in), .ch_mask(ch_mask),
    .spi_sck(sck[0]), .spi_sdo(sdo[0]), .spi_dac_cs(cs[0]), .ena_out(ena[0]),
    .busy(busy[0]), .overrun(ovr[0]), .dbg_state(dbg[0]));

  spi_dac_multi_out #(.CHANNELS(CHANNELS), .DATA_W(DATA_W), .CLK_DIV(CLK_DIV),
                      .CS_GAP(CS_GAP), .CYC_W(CYC_W), .SIMUL_UPD(1)) u_dut1 (
    .clk(clk), .reset_n(reset_n), .cycles(cycles), .data_in(data_in), .ch_mask(ch_mask),
    .spi_sck(sck[1]), .spi_sdo(sdo[1]), .spi_dac_cs(cs[1]), .ena_out(ena[1]),
    .busy(busy[1]), .overrun(ovr[1]), .dbg_state(dbg[1]));

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Inputs as seen at the last rising edge (what a frame start would latch)
  logic [CYC_W-1:0]           snap_cyc;
  logic [CHANNELS-1:0]        snap_mask;
  logic [CHANNELS*DATA_W-1:0] snap_data;
  always @(posedge clk) begin
    snap_cyc  <= cycles;
    snap_mask <= ch_mask;
    snap_data <= data_in;
  end

  // ---------------- model + scoreboard per lane ----------------
  for (genvar g = 0; g < 2; g++) begin : lane
    logic [23:0]       exp_q[$];
    logic [23:0]       shift_w;
    int                nbits;
    logic              sdo_prev;
    bit                have_prev;
    int                cyc_ctr, ovr_cnt, exp_period, exp_ovr, n, hi, ceff;
    logic [3:0]        cmd;
    logic [DATA_W-1:0] smp;
    logic [15:0]       d16;

    // Reference model: frame bookkeeping and expected words at each frame start
    always @(negedge clk) begin
      sdo_prev = sdo[g];
      if (!reset_n) begin
        have_prev = 1'b0;
        cyc_ctr   = 0;
        ovr_cnt   = 0;
      end else begin
        cyc_ctr++;
        if (ovr[g] === 1'b1) ovr_cnt++;
        if (ena[g] === 1'b1) begin
          if (have_prev) begin
            check($sformatf("lane%0d_ena_period", g), cyc_ctr, exp_period);
            check($sformatf("lane%0d_overrun_count", g), ovr_cnt, exp_ovr);
          end
          n  = 0;
          hi = -1;
          for (int k = 0; k < CHANNELS; k++) if (snap_mask[k]) begin n++; hi = k; end
          ceff       = (snap_cyc < 2) ? 2 : int'(snap_cyc);
          exp_period = (n*WORD_CLKS > ceff) ? n*WORD_CLKS : ceff;
          exp_ovr    = (n*WORD_CLKS > ceff) ? 1 : 0;
          for (int k = 0; k < CHANNELS; k++) begin
            if (snap_mask[k]) begin
              if (g == 0)      cmd = 4'b0011;
              else if (k == hi) cmd = 4'b0010;
              else             cmd = 4'b0000;
              smp = snap_data[k*DATA_W +: DATA_W];
              d16 = 16'(int'(smp) * (1 << (16 - DATA_W)));
              exp_q.push_back({cmd, 4'(k), d16});
            end
          end
          q_size[g] = exp_q.size();
          cyc_ctr   = 0;
          ovr_cnt   = 0;
          have_prev = 1'b1;
        end
      end
    end

    // A reset abandons every word in flight
    always @(negedge reset_n) begin
      exp_q.delete();
      q_size[g] = 0;
    end

    always @(negedge cs[g]) begin
      shift_w = '0;
      nbits   = 0;
    end

    // SPI capture on SCK rising edges, with framing and setup checks
    always @(posedge sck[g]) begin
      check($sformatf("lane%0d_cs_low_at_sck_rise", g), cs[g], 1'b0);
      check($sformatf("lane%0d_sdo_setup", g), sdo[g], sdo_prev);
      check($sformatf("lane%0d_busy_in_word", g), busy[g], 1'b1);
      shift_w = {shift_w[22:0], sdo[g]};
      nbits++;
    end

    // Word complete at CS rising edge: pop and compare
    always @(posedge cs[g]) begin
      if (reset_n === 1'b1) begin
        check($sformatf("lane%0d_word_bits", g), nbits, 24);
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL lane%0d_unexpected_word: got %06h expected none", g, shift_w);
        end else begin
          check($sformatf("lane%0d_word", g), shift_w, exp_q.pop_front());
        end
        q_size[g] = exp_q.size();
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic run(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_shift();
    int i;
    for (i = 0; i < 2000 && dbg[0] !== ST_SHIFT; i++) @(negedge clk);
    check("wait_shift_reached", dbg[0] === ST_SHIFT, 1'b1);
  endtask

  task automatic check_idle_outputs(input string tag);
    for (int g = 0; g < 2; g++) begin
      check($sformatf("%s_lane%0d_sck", tag, g), sck[g], 1'b0);
      check($sformatf("%s_lane%0d_cs", tag, g), cs[g], 1'b1);
      check($sformatf("%s_lane%0d_busy", tag, g), busy[g], 1'b0);
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int i;
    cycles  = 16'd200;
    ch_mask = 4'b0001;
    data_in = '0;
    data_in[11:0] = 12'hABC;
    repeat (3) @(negedge clk);
    check_idle_outputs("reset");
    for (int g = 0; g < 2; g++) begin
      check($sformatf("reset_lane%0d_sdo", g), sdo[g], 1'b0);
      check($sformatf("reset_lane%0d_ena", g), ena[g], 1'b0);
      check($sformatf("reset_lane%0d_overrun", g), ovr[g], 1'b0);
    end
    reset_n = 1'b1;

    // single channel, 200-clk frames
    run(1000);

    // four channels, no overrun
    data_in = {12'h444, 12'h333, 12'h222, 12'h111};
    ch_mask = 4'b1111;
    cycles  = 16'd300;
    run(1200);

    // frame longer than the timer period: stretched frames with overrun
    cycles = 16'd50;
    run(1000);

    // inputs changed while words are shifting
    cycles = 16'd260;
    repeat (4) begin
      wait_shift();
      data_in = 48'({$urandom(), $urandom()});
      ch_mask = 4'($urandom_range(1, 15));
      run($urandom_range(20, 300));
    end

    // reset in the middle of a word
    cycles  = 16'd120;
    ch_mask = 4'b0110;
    wait_shift();
    repeat (7) @(negedge clk);
    reset_n = 1'b0;
    #1;
    check_idle_outputs("midreset");
    repeat (4) @(negedge clk);
    reset_n = 1'b1;
    run(600);

    // empty mask: timer only; then sub-minimum period
    ch_mask = '0;
    cycles  = 16'd10;
    run(300);
    cycles  = 16'd1;
    run(40);

    // random frames
    repeat (25) begin
      cycles  = 16'($urandom_range(0, 320));
      ch_mask = 4'($urandom());
      data_in = 48'({$urandom(), $urandom()});
      run($urandom_range(50, 700));
    end

    // drain
    ch_mask = '0;
    cycles  = 16'd10;
    for (i = 0; i < 3000 && !(q_size[0] == 0 && q_size[1] == 0 &&
                              busy[0] === 1'b0 && busy[1] === 1'b0); i++)
      @(negedge clk);
    check("drain_lane0_queue_empty", q_size[0], 0);
    check("drain_lane1_queue_empty", q_size[1], 0);
    check_idle_outputs("drain");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
